// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-ported memory between fetch (IF) and data (D); `ARB_TIMEOUT_EN adds a response watchdog.
// Latency: accept -> o_mem_valid next cycle; port rvalid the cycle after i_mem_rvalid (3 cycles per transaction at zero wait).
// Backpressure: one transaction in flight; both port readies stay low from acceptance until the response has been taken.
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_if_valid,
  output logic            o_if_ready,
  input  logic [AW-1:0]   i_if_addr,
  output logic            o_if_rvalid,
  output logic [DW-1:0]   o_if_rdata,
  input  logic            i_d_valid,
  output logic            o_d_ready,
  input  logic [AW-1:0]   i_d_addr,
  input  logic            i_d_we,
  input  logic [DW-1:0]   i_d_wdata,
  input  logic [DW/8-1:0] i_d_wstrb,
  output logic            o_d_rvalid,
  output logic [DW-1:0]   o_d_rdata,
  output logic            o_mem_valid,
  input  logic            i_mem_ready,
  output logic [AW-1:0]   o_mem_addr,
  output logic            o_mem_we,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_wstrb,
  input  logic            i_mem_rvalid,
  input  logic [DW-1:0]   i_mem_rdata,
`ifdef ARB_TIMEOUT_EN
  output logic            o_if_err,
  output logic            o_d_err,
`endif
  output logic            o_grant,
  output logic            o_busy
);

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            we;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
  } req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  req_t   req_q, req_nxt;
  logic   acc_vld;
  logic   done;
  logic   abort;

  // o_grant doubles as last_grant: the port opposite it wins a tie.
  always_comb begin
    o_if_ready = 1'b0;
    o_d_ready  = 1'b0;
    if (state == IDLE && !rst) begin
      o_if_ready = i_if_valid && (!i_d_valid || o_grant);
      o_d_ready  = i_d_valid && (!i_if_valid || !o_grant);
    end
  end

  assign acc_vld = o_if_ready || o_d_ready;
  assign done    = (state == RESP) && i_mem_rvalid;

  always_comb begin
    req_nxt = '0;
    if (o_d_ready) begin
      req_nxt.addr  = i_d_addr;
      req_nxt.we    = i_d_we;
      req_nxt.wdata = i_d_wdata;
      req_nxt.wstrb = i_d_wstrb;
    end else begin
      req_nxt.addr  = i_if_addr;
      req_nxt.wstrb = '1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt;

  // Fires on the edge where the count reaches TIMEOUT_CYCLES; a response on that edge still wins.
  assign abort = (state != IDLE) && (tmo_cnt == TMO_LAST) && !done;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt  <= '0;
      o_if_err <= 1'b0;
      o_d_err  <= 1'b0;
    end else begin
      o_if_err <= abort && !o_grant;
      o_d_err  <= abort && o_grant;
      if (acc_vld) begin
        tmo_cnt <= '0;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (acc_vld) state_nxt = REQ;
      REQ: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (i_mem_ready) begin
          state_nxt = RESP;
        end
      end
      RESP:    if (done || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= '0;
      o_grant     <= 1'b0;
      o_if_rvalid <= 1'b0;
      o_d_rvalid  <= 1'b0;
      o_if_rdata  <= '0;
      o_d_rdata   <= '0;
    end else begin
      state       <= state_nxt;
      o_if_rvalid <= (done || abort) && !o_grant;
      o_d_rvalid  <= (done || abort) && o_grant;
      if (acc_vld) begin
        req_q   <= req_nxt;
        o_grant <= o_d_ready;
      end
      // An aborted transaction returns zero data, stores included.
      if (abort) begin
        if (o_grant) o_d_rdata <= '0;
        else         o_if_rdata <= '0;
      end else if (done && !req_q.we) begin
        if (o_grant) o_d_rdata <= i_mem_rdata;
        else         o_if_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_mem_valid = (state == REQ);
  assign o_busy      = (state != IDLE);
  assign o_mem_addr  = req_q.addr;
  assign o_mem_we    = req_q.we;
  assign o_mem_wdata = req_q.wdata;
  assign o_mem_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: bench-driven memory responder, transaction-level model, per-cycle compare.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_if_valid = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic        i_d_valid = 1'b0;
  logic [31:0] i_d_addr = '0;
  logic        i_d_we = 1'b0;
  logic [31:0] i_d_wdata = '0;
  logic [3:0]  i_d_wstrb = '0;
  logic        i_mem_ready = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_if_ready, o_if_rvalid, o_d_ready, o_d_rvalid;
  logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
  logic        o_mem_valid, o_mem_we, o_grant, o_busy;
  logic [3:0]  o_mem_wstrb;
`ifdef ARB_TIMEOUT_EN
  logic        o_if_err, o_d_err;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_if_valid(i_if_valid), .o_if_ready(o_if_ready), .i_if_addr(i_if_addr),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_valid(i_d_valid), .o_d_ready(o_d_ready), .i_d_addr(i_d_addr), .i_d_we(i_d_we),
    .i_d_wdata(i_d_wdata), .i_d_wstrb(i_d_wstrb), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
`ifdef ARB_TIMEOUT_EN
    .o_if_err(o_if_err), .o_d_err(o_d_err),
`endif
    .o_grant(o_grant), .o_busy(o_busy)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Memory contents, written only by the main sequence.
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // Memory responder: ready after cfg_rdy_dly waiting cycles, rvalid cfg_rsp_dly cycles into the response phase.
  int          cfg_rdy_dly = 0;
  int          cfg_rsp_dly = 0;
  bit          cfg_silent  = 1'b0;
  bit          stray       = 1'b0;
  int          rq_cnt = 0;
  int          rs_cnt = 0;
  bit          wait_rsp = 1'b0;
  logic [31:0] rs_addr = '0;

  always @(negedge clk) begin
    #1;
    i_mem_ready  = 1'b0;
    i_mem_rvalid = stray;
    i_mem_rdata  = stray ? 32'hBAD0_BAD0 : 32'h0;
    if (rst) begin
      wait_rsp = 1'b0;
      rq_cnt   = 0;
    end else if (wait_rsp) begin
      if (!cfg_silent) begin
        if (rs_cnt >= cfg_rsp_dly) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = mem_rd(rs_addr);
          wait_rsp     = 1'b0;
          rq_cnt       = 0;
        end else begin
          rs_cnt++;
        end
      end
    end else if (o_mem_valid) begin
      if (rq_cnt >= cfg_rdy_dly) begin
        i_mem_ready = 1'b1;
        wait_rsp    = 1'b1;
        rs_cnt      = 0;
        rs_addr     = o_mem_addr;
      end else begin
        rq_cnt++;
      end
    end
  end

  // Transaction-level model: at most one outstanding transaction, tracked from acceptance to its response.
  bit          m_have = 0, m_sent = 0, m_owner = 0, m_last = 0, m_we = 0;
  int          m_age = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_d_rd = '0;
  logic [3:0]  m_strb = '0;
  bit          m_if_pv = 0, m_d_pv = 0, m_if_ev = 0, m_d_ev = 0;
  int          cyc = 0;

  function automatic bit e_if_rdy();
    return !m_have && !rst && i_if_valid && (!i_d_valid || m_last);
  endfunction
  function automatic bit e_d_rdy();
    return !m_have && !rst && i_d_valid && (!i_if_valid || !m_last);
  endfunction

  always @(posedge clk) begin
    bit take_if, take_d;
    take_if = e_if_rdy();
    take_d  = e_d_rdy();
    cyc++;
    m_if_pv = 0; m_d_pv = 0; m_if_ev = 0; m_d_ev = 0;
    if (rst) begin
      m_have = 0; m_sent = 0; m_last = 0; m_if_rd = '0; m_d_rd = '0;
    end else if (m_have) begin
      m_age++;
      if (m_sent && i_mem_rvalid) begin
        if (m_owner) m_d_pv = 1; else m_if_pv = 1;
        if (!m_we) begin
          if (m_owner) m_d_rd = i_mem_rdata; else m_if_rd = i_mem_rdata;
        end
        m_have = 0;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_age == TMO) begin
        if (m_owner) begin m_d_pv = 1; m_d_ev = 1; m_d_rd = '0; end
        else begin m_if_pv = 1; m_if_ev = 1; m_if_rd = '0; end
        m_have = 0;
      end
`endif
      else if (!m_sent && i_mem_ready) m_sent = 1;
    end else if (take_if || take_d) begin
      m_have  = 1; m_sent = 0; m_age = 0;
      m_owner = take_d; m_last = take_d;
      m_addr  = take_d ? i_d_addr : i_if_addr;
      m_we    = take_d && i_d_we;
      m_wdata = i_d_wdata;
      m_strb  = take_d ? i_d_wstrb : 4'hF;
    end
  end

  // Per-cycle compare plus bookkeeping for the directed checks.
  bit chk_en = 1'b0;
  int acc_if = 0, acc_d = 0, rsp_if = 0, rsp_d = 0, n_if = 0, n_d = 0, viol = 0;
  bit order [$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("if_ready", o_if_ready, e_if_rdy());
      chk("d_ready", o_d_ready, e_d_rdy());
      chk("busy", o_busy, m_have);
      chk("mem_valid", o_mem_valid, m_have && !m_sent);
      chk("grant", o_grant, m_last);
      chk("if_rvalid", o_if_rvalid, m_if_pv);
      chk("d_rvalid", o_d_rvalid, m_d_pv);
      chk("if_rdata", o_if_rdata, m_if_rd);
      chk("d_rdata", o_d_rdata, m_d_rd);
`ifdef ARB_TIMEOUT_EN
      chk("if_err", o_if_err, m_if_ev);
      chk("d_err", o_d_err, m_d_ev);
`endif
      if (m_have && !m_sent) begin
        chk("mem_addr", o_mem_addr, m_addr);
        chk("mem_we", o_mem_we, m_we);
        chk("mem_wstrb", o_mem_wstrb, m_strb);
        if (m_we) chk("mem_wdata", o_mem_wdata, m_wdata);
      end
      if (o_if_ready && i_if_valid) begin acc_if = cyc; order.push_back(1'b0); end
      if (o_d_ready && i_d_valid)   begin acc_d = cyc;  order.push_back(1'b1); end
      if (o_if_rvalid) begin rsp_if = cyc; n_if++; end
      if (o_d_rvalid)  begin rsp_d = cyc;  n_d++;  end
      if (o_busy && (o_if_ready || o_d_ready)) viol++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit port, input logic [31:0] a, input bit we, input logic [31:0] wd, input logic [3:0] st);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (port) begin
      i_d_valid = 1'b1; i_d_addr = a; i_d_we = we; i_d_wdata = wd; i_d_wstrb = st;
    end else begin
      i_if_valid = 1'b1; i_if_addr = a;
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (port ? o_d_ready : o_if_ready) begin got = 1'b1; break; end
    end
    chk(port ? "d_accept_seen" : "if_accept_seen", got, 1);
    @(posedge clk); #1;
    if (port) i_d_valid = 1'b0; else i_if_valid = 1'b0;
  endtask

  task automatic wait_rsp_pulse(input bit port, input int limit);
    bit got = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (port ? o_d_rvalid : o_if_rvalid) begin got = 1'b1; break; end
    end
    #2;
    chk(port ? "d_rsp_seen" : "if_rsp_seen", got, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_if, b_d, b_viol, b_ord;
    bit got;
    mem[32'h0000_0014] = 32'hDEAD_BEEF;

    // Reset state.
    cycles(1);
    chk_en = 1'b1;
    cycles(2);
    chk("rst_busy", o_busy, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_if_rdata", o_if_rdata, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_wstrb", o_mem_wstrb, 0);
    rst = 1'b0;

    // Single fetch, zero-wait memory.
    b_d = n_d;
    issue(1'b0, 32'h0000_0014, 1'b0, 32'h0, 4'h0);
    wait_rsp_pulse(1'b0, 20);
    chk("fetch_latency", rsp_if - acc_if, 3);
    chk("fetch_rdata", o_if_rdata, 32'hDEAD_BEEF);
    chk("fetch_mem_addr", o_mem_addr, 32'h14);
    chk("fetch_mem_we", o_mem_we, 0);
    chk("fetch_mem_wstrb", o_mem_wstrb, 4'hF);
    chk("fetch_no_d_rvalid", n_d - b_d, 0);

    // D load, then a store held through 3 cycles of mem_ready low.
    issue(1'b1, 32'h0000_0014, 1'b0, 32'h0, 4'hF);
    wait_rsp_pulse(1'b1, 20);
    cfg_rdy_dly = 3;
    b_d = n_d;
    issue(1'b1, 32'h0000_2004, 1'b1, 32'h0000_0101, 4'b0011);
    wait_rsp_pulse(1'b1, 30);
    chk("store_latency", rsp_d - acc_d, 6);
    chk("store_pulses", n_d - b_d, 1);
    chk("store_rdata_kept", o_d_rdata, 32'hDEAD_BEEF);
    chk("store_mem_we", o_mem_we, 1);
    chk("store_mem_wdata", o_mem_wdata, 32'h0000_0101);
    chk("store_mem_wstrb", o_mem_wstrb, 4'b0011);
    cfg_rdy_dly = 0;

    // Contention straight out of reset: D, IF, D, IF.
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    mem[32'h0000_0014] = 32'h0000_0010;
    mem[32'h0000_2003] = 32'h0000_0013;
    b_if = n_if; b_d = n_d; b_ord = order.size();
    i_d_valid = 1'b1; i_d_addr = 32'h14; i_d_we = 1'b0;
    i_if_valid = 1'b1; i_if_addr = 32'h2003;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #2;
      if (order.size() >= b_ord + 4) begin got = 1'b1; break; end
    end
    chk("contend_four_grants", got, 1);
    @(posedge clk); #1;
    i_d_valid = 1'b0; i_if_valid = 1'b0;
    wait_rsp_pulse(1'b0, 20);
    if (got) begin
      chk("contend_grant0", order[b_ord],   1);
      chk("contend_grant1", order[b_ord+1], 0);
      chk("contend_grant2", order[b_ord+2], 1);
      chk("contend_grant3", order[b_ord+3], 0);
    end
    chk("contend_d_rdata", o_d_rdata, 32'h10);
    chk("contend_if_rdata", o_if_rdata, 32'h13);
    chk("contend_d_pulses", n_d - b_d, 2);
    chk("contend_if_pulses", n_if - b_if, 2);

    // Memory backpressure with a D request waiting throughout.
    cfg_rdy_dly = 5; cfg_rsp_dly = 2;
    b_if = n_if; b_viol = viol;
    issue(1'b0, 32'h0000_0030, 1'b0, 32'h0, 4'h0);
    issue(1'b1, 32'h0000_0040, 1'b0, 32'h0, 4'hF);
    wait_rsp_pulse(1'b1, 30);
    chk("bp_if_latency", rsp_if - acc_if, 10);
    chk("bp_if_pulses", n_if - b_if, 1);
    chk("bp_d_accept_in_pulse", acc_d, rsp_if);
    chk("bp_ready_while_busy", viol - b_viol, 0);
    cfg_rdy_dly = 0;

    // Reset while waiting for the response, then a stray rvalid.
    cfg_rsp_dly = 5;
    b_d = n_d;
    issue(1'b1, 32'h0000_0014, 1'b0, 32'h0, 4'hF);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_busy && !o_mem_valid) begin got = 1'b1; break; end
    end
    chk("rst_resp_reached", got, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0; stray = 1'b1;
    cycles(1);
    stray = 1'b0;
    cycles(3);
    chk("rst_resp_busy", o_busy, 0);
    chk("rst_resp_d_rdata", o_d_rdata, 0);
    chk("rst_resp_no_pulse", n_d - b_d, 0);
    cfg_rsp_dly = 0;
    issue(1'b0, 32'h0000_2003, 1'b0, 32'h0, 4'h0);
    wait_rsp_pulse(1'b0, 20);
    chk("post_rst_latency", rsp_if - acc_if, 3);
    chk("post_rst_if_rdata", o_if_rdata, 32'h13);

`ifdef ARB_TIMEOUT_EN
    // Memory never answers a D load.
    issue(1'b1, 32'h0000_0014, 1'b0, 32'h0, 4'hF);
    wait_rsp_pulse(1'b1, 20);
    cfg_silent = 1'b1;
    issue(1'b1, 32'h0000_0018, 1'b0, 32'h0, 4'hF);
    wait_rsp_pulse(1'b1, 40);
    chk("tmo_latency", rsp_d - acc_d, 17);
    chk("tmo_err", o_d_err, 1);
    chk("tmo_rdata", o_d_rdata, 0);
    chk("tmo_idle", o_busy, 0);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cfg_silent = 1'b0;
`endif

    cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: instruction fetch (port IF, read-only) and the Memory stage (port D, load/store).
- Accepts one transaction at a time through valid/ready handshakes and forwards it to the memory.
- Waits for the memory's response, then routes the read data or write acknowledgement back to the requester that issued the transaction.
- Sits between the fetch/Memory pipeline stages and the memory model/controller.

Parameters:
- AW, 32, address width
- DW, 32, data width; strobe width is DW/8
- TIMEOUT_CYCLES, 16, response timeout in cycles (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_if_valid  in  1  fetch request
- o_if_ready  out  1  fetch request accepted this cycle
- i_if_addr  in  AW  fetch address
- o_if_rvalid  out  1  one-cycle pulse: fetch response
- o_if_rdata  out  DW  fetch data
- i_d_valid  in  1  data request
- o_d_ready  out  1  data request accepted this cycle
- i_d_addr  in  AW  data address
- i_d_we  in  1  1=store, 0=load
- i_d_wdata  in  DW  store data
- i_d_wstrb  in  DW/8  byte enables
- o_d_rvalid  out  1  one-cycle pulse: load data or store ack
- o_d_rdata  out  DW  load data
- o_mem_valid  out  1  request to memory
- i_mem_ready  in  1  memory accepts the request
- o_mem_addr  out  AW  latched address
- o_mem_we  out  1  latched write enable (0 for fetch)
- o_mem_wdata  out  DW  latched write data
- o_mem_wstrb  out  DW/8  latched strobes (all ones for fetch)
- i_mem_rvalid  in  1  memory response/ack
- i_mem_rdata  in  DW  memory read data
- o_grant  out  1  owner of the current or last transaction (0=IF, 1=D)
- o_busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE. All outputs 0, including rdata registers and latched memory fields. last_grant=IF, so D wins the first tie.
- States:
  - IDLE: wait for a request.
  - REQ: o_mem_valid=1 with the latched fields.
  - RESP: wait for i_mem_rvalid.
- IDLE arbitration (combinational ready):
  - Only one valid: that port's ready=1.
  - Both valid: round-robin; grant the port opposite last_grant.
  - At most one ready is high. Ready is always 0 outside IDLE.
- Acceptance (valid && ready): latch addr/we/wdata/wstrb and the grant, update last_grant and o_grant, go to REQ.
- REQ -> RESP on i_mem_ready. The latched fields stay stable until then.
- RESP, on i_mem_rvalid:
  - Next cycle, the granted port's rvalid pulses for exactly one cycle.
  - Read: i_mem_rdata is registered into that port's rdata. Store: rdata is unchanged.
  - State returns to IDLE on the same edge.
- New acceptance is legal in the cycle the rvalid pulse is high.
- Zero-wait memory latency: accept at edge N; REQ at N+1 (mem_ready); RESP at N+2 (rvalid); port rvalid at N+3. One transaction per 3 cycles.
- o_x_rdata holds its value until the next read response to that port.
- i_mem_rvalid outside RESP is ignored. i_mem_ready outside REQ is ignored.
- Requester valid deasserting without acceptance is legal; no state change results.
- Reset mid-transaction: return immediately to IDLE, outputs cleared, the transaction is abandoned. A late i_mem_rvalid after reset is ignored.
- Fetch transactions always drive o_mem_we=0 and o_mem_wstrb all ones.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on acceptance and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT_CYCLES with no completion, the transaction is aborted: o_mem_valid drops, state goes to IDLE.
  - The owner's rvalid pulses next cycle with rdata=0 (reads and stores alike) and its error output asserted for the same cycle.
  - Adds ports o_if_err and o_d_err (out, 1, reset 0).
  - Completion on the timeout cycle itself wins over abort.
- Undefined: no counter and no err ports; the arbiter waits indefinitely.

Test Plan:
- Single fetch, zero-wait memory: i_if_addr=0x0000_0014 accepted at edge N, mem returns 0xDEAD_BEEF -> o_mem_addr=0x14, o_mem_we=0, o_if_rvalid at N+3, o_if_rdata=0xDEAD_BEEF, o_d_rvalid stays 0.
- Store: D addr=0x0000_2004, wdata=0x0000_0101, wstrb=4'b0011 -> o_mem_we=1 with these values held through 3 cycles of i_mem_ready=0; o_d_rvalid pulses once after ack; o_d_rdata unchanged.
- Contention: both valid continuously after reset -> grants D, IF, D, IF; o_grant follows the same order; each port receives its own data (D reads 0x10 from 0x14, IF reads 0x13 from 0x2003).
- Memory backpressure: i_mem_ready low for 5 cycles, rvalid 2 cycles later -> o_if_ready/o_d_ready=0 and o_busy=1 throughout; exactly one response pulse.
- Reset in RESP, then a stray i_mem_rvalid -> all outputs 0, no rvalid pulse, next request served normally.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, memory never responds to D load -> o_d_rvalid and o_d_err pulse together 17 cycles after acceptance, o_d_rdata=0, arbiter back in IDLE.
